// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Arbitrates NUM_CH block-read/block-write requesters onto a single AXI
//   engine. One transaction is in flight at a time: a winner is picked in
//   IDLE, its request is latched, a start pulse is issued, the engine's
//   completion (or a WAIT timeout) is awaited, and a one-cycle done pulse is
//   returned to the owner.
//
//   State table
//     state   | meaning
//     --------+-------------------------------------------------------------
//     S_IDLE  | no owner; pick a winner from i_req and latch its request
//     S_ISSUE | pulse the read or write start to the AXI engine
//     S_WAIT  | wait for i_axi_done; the timeout counter runs here
//     S_RESP  | o_done = o_grant for one cycle, then release the grant
//
//   Ports
//     i_clk, i_rstn          clock, synchronous active-low reset
//     i_req, i_we            per-channel request level / write-not-read
//     i_addr, i_wdata        per-channel address / write block (channel k at
//                            [k*W +: W])
//     o_grant, o_done        one-hot owner / one-hot completion pulse
//     o_err, o_timeout       timeout pulse with o_done / sticky timeout flag
//     o_rdata                last block read
//     o_axi_addr             latched address to the AXI engine
//     o_data_block           latched write block to the AXI engine
//     o_axi_write_start      one-cycle write start
//     o_axi_read_start       one-cycle read start
//     i_axi_done             AXI engine completion (honoured only in S_WAIT)
//     i_data_block           read block from the AXI engine
module mem_req_arbiter #(
   parameter int NUM_CH      = 3,
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int RR_MODE     = 0,
   parameter int TIMEOUT     = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   input  logic [NUM_CH-1:0]             i_req,
   input  logic [NUM_CH-1:0]             i_we,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]  i_addr,
   input  logic [NUM_CH*BLOCK_WIDTH-1:0] i_wdata,
   output logic [NUM_CH-1:0]             o_grant,
   output logic [NUM_CH-1:0]             o_done,
   output logic                          o_err,
   output logic [BLOCK_WIDTH-1:0]        o_rdata,
   output logic                          o_timeout,
   output logic [ADDR_WIDTH-1:0]         o_axi_addr,
   output logic [BLOCK_WIDTH-1:0]        o_data_block,
   output logic                          o_axi_write_start,
   output logic                          o_axi_read_start,
   input  logic                          i_axi_done,
   input  logic [BLOCK_WIDTH-1:0]        i_data_block
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [NUM_CH-1:0]       r_grant;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [BLOCK_WIDTH-1:0]  r_wdata;
   logic [BLOCK_WIDTH-1:0]  r_rdata;
   logic                    r_err;
   logic                    r_timeout;
   logic [PW-1:0]           r_rr_ptr;
   logic [CW-1:0]           r_cnt;

   logic [PW-1:0]           w_cand [NUM_CH];
   logic [PW-1:0]           w_win_idx;
   logic                    w_win_vld;
   logic [NUM_CH-1:0]       w_win_oh;
   logic [PW-1:0]           w_ptr_nxt;
   logic [ADDR_WIDTH-1:0]   w_sel_addr;
   logic [BLOCK_WIDTH-1:0]  w_sel_wdata;
   logic                    w_sel_we;
   logic [CW-1:0]           w_cnt_inc;
   logic                    w_tmo;

   // Search order: plain 0..N-1 for fixed priority, rotated by the pointer
   // for round-robin.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (RR_MODE != 0) begin
            w_cand[i] = PW'((int'(r_rr_ptr) + i) % NUM_CH);
         end else begin
            w_cand[i] = PW'(i);
         end
      end
   end

   always_comb begin
      w_win_idx = '0;
      w_win_vld = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!w_win_vld && i_req[w_cand[i]]) begin
            w_win_vld = 1'b1;
            w_win_idx = w_cand[i];
         end
      end
   end

   assign w_win_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << w_win_idx;
   assign w_ptr_nxt = (w_win_idx == PW'(NUM_CH - 1)) ? '0 : w_win_idx + 1'b1;

   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_we    = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_win_idx == PW'(c)) begin
            w_sel_addr  = i_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_wdata = i_wdata[c*BLOCK_WIDTH +: BLOCK_WIDTH];
            w_sel_we    = i_we[c];
         end
      end
   end

   // The counter value after this WAIT cycle; hitting TIMEOUT on the same
   // cycle as i_axi_done is treated as a normal completion.
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   assign w_tmo     = (TIMEOUT != 0) && (r_state == S_WAIT) && !i_axi_done &&
                      (w_cnt_inc == CW'(TIMEOUT));

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_win_vld) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (i_axi_done || w_tmo) w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      o_grant           = r_grant;
      o_done            = (r_state == S_RESP) ? r_grant : '0;
      o_err             = (r_state == S_RESP) && r_err;
      o_axi_read_start  = (r_state == S_ISSUE) && !r_we;
      o_axi_write_start = (r_state == S_ISSUE) && r_we;
      o_rdata           = r_rdata;
      o_timeout         = r_timeout;
      o_axi_addr        = r_addr;
      o_data_block      = r_wdata;
   end

   // Transaction datapath
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_grant   <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         r_rr_ptr  <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_grant <= w_win_oh;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
                  r_we    <= w_sel_we;
                  if (RR_MODE != 0) r_rr_ptr <= w_ptr_nxt;
               end
            end
            S_ISSUE: begin
               r_cnt <= '0;
               r_err <= 1'b0;
            end
            S_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (i_axi_done) begin
                  if (!r_we) r_rdata <= i_data_block;
               end else if (w_tmo) begin
                  r_err     <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            S_RESP: begin
               r_grant <= '0;
               r_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

   localparam int NC  = 3;
   localparam int AW  = 64;
   localparam int BW  = 512;
   localparam int TMO = 8;

   localparam logic [BW-1:0] PAT_A5 = {64{8'hA5}};
   localparam logic [BW-1:0] PAT_5A = {64{8'h5A}};
   localparam logic [BW-1:0] PAT_C3 = {64{8'hC3}};
   localparam logic [BW-1:0] WD0    = {16{32'h89ABCDEF}};
   localparam logic [BW-1:0] WD1    = {16{32'h01234567}};
   localparam logic [BW-1:0] WD2    = {16{32'hDEADBEEF}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rstn;
   logic [NC-1:0]    req0, req1, we;
   logic [NC*AW-1:0] addr;
   logic [NC*BW-1:0] wdata;
   logic             axi_done;
   logic [BW-1:0]    axi_data;

   logic [NC-1:0] d0_grant, d0_done, d1_grant, d1_done;
   logic          d0_err, d0_tmo, d0_ws, d0_rs, d1_err, d1_tmo, d1_ws, d1_rs;
   logic [BW-1:0] d0_rdata, d0_blk, d1_rdata, d1_blk;
   logic [AW-1:0] d0_addr, d1_addr;

   mem_req_arbiter #(.NUM_CH(NC), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW),
                     .RR_MODE(0), .TIMEOUT(TMO)) dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req0), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .o_grant(d0_grant), .o_done(d0_done), .o_err(d0_err),
      .o_rdata(d0_rdata), .o_timeout(d0_tmo), .o_axi_addr(d0_addr),
      .o_data_block(d0_blk), .o_axi_write_start(d0_ws),
      .o_axi_read_start(d0_rs), .i_axi_done(axi_done),
      .i_data_block(axi_data));

   mem_req_arbiter #(.NUM_CH(NC), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW),
                     .RR_MODE(1), .TIMEOUT(TMO)) dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req1), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .o_grant(d1_grant), .o_done(d1_done), .o_err(d1_err),
      .o_rdata(d1_rdata), .o_timeout(d1_tmo), .o_axi_addr(d1_addr),
      .o_data_block(d1_blk), .o_axi_write_start(d1_ws),
      .o_axi_read_start(d1_rs), .i_axi_done(axi_done),
      .i_data_block(axi_data));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [NC-1:0] done;
      logic          err;
      logic [BW-1:0] rdata;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t          q0[$];
   logic [NC-1:0] q1[$];
   exp_t          m0_e;
   logic [NC-1:0] m1_e;

   task automatic push0(input logic [NC-1:0] g, input logic e,
                        input logic [BW-1:0] r, input logic [AW-1:0] a);
      exp_t x;
      x.done = g; x.err = e; x.rdata = r; x.addr = a;
      q0.push_back(x);
   endtask

   always @(negedge clk) begin
      if ((|d0_done) === 1'b1) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_done", BW'(d0_done), '0);
         end else begin
            m0_e = q0.pop_front();
            chk("sb0_done",  BW'(d0_done),  BW'(m0_e.done));
            chk("sb0_grant", BW'(d0_grant), BW'(m0_e.done));
            chk("sb0_err",   BW'(d0_err),   BW'(m0_e.err));
            chk("sb0_rdata", d0_rdata,      m0_e.rdata);
            chk("sb0_addr",  BW'(d0_addr),  BW'(m0_e.addr));
         end
      end else if (d0_err === 1'b1) begin
         chk("dut0_err_without_done", BW'(d0_err), '0);
      end
   end

   always @(negedge clk) begin
      if ((|d1_done) === 1'b1) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_done", BW'(d1_done), '0);
         end else begin
            m1_e = q1.pop_front();
            chk("sb1_done",  BW'(d1_done),  BW'(m1_e));
            chk("sb1_grant", BW'(d1_grant), BW'(m1_e));
            chk("sb1_err",   BW'(d1_err),   '0);
         end
      end
   end

   // ---------------- AXI engine responder ----------------
   // resp_delay = n asserts i_axi_done in the n-th WAIT cycle; 0 = never.
   int            resp_delay;
   logic [BW-1:0] resp_data;
   int            rsp_d;
   initial begin
      axi_done = 1'b0;
      axi_data = '0;
      forever begin
         @(negedge clk);
         if ((d0_rs | d0_ws | d1_rs | d1_ws) === 1'b1 && resp_delay > 0) begin
            rsp_d = resp_delay;
            @(posedge clk);
            repeat (rsp_d - 1) @(posedge clk);
            #1 axi_done = 1'b1;
            axi_data = resp_data;
            @(posedge clk);
            #1 axi_done = 1'b0;
         end
      end
   end

   // ---------------- dut0 transaction watcher ----------------
   int            ws_start, ws_done, ws_nrd, ws_nwr, ws_bad;
   logic [NC-1:0] ws_grant;

   task automatic watch0(input int maxc, input bit drop_early,
                         input logic [AW-1:0] ea, input logic [BW-1:0] eb, input bit ckb);
      bit started;
      started = 0;
      ws_start = -1; ws_done = -1; ws_nrd = 0; ws_nwr = 0; ws_bad = 0; ws_grant = '0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if ((d0_rs | d0_ws) === 1'b1) begin
            if (!started) begin
               started  = 1;
               ws_start = cyc;
               ws_grant = d0_grant;
            end
            ws_nrd += int'(d0_rs);
            ws_nwr += int'(d0_ws);
         end
         if (started) begin
            if (d0_addr !== ea) ws_bad++;
            if (ckb && d0_blk !== eb) ws_bad++;
         end
         if ((|d0_done) === 1'b1) begin
            ws_done = cyc;
            req0 = req0 & ~d0_done;
            break;
         end
         if (started && drop_early) req0 = req0 & ~ws_grant;
      end
      if (ws_done < 0) chk("watch0_done_seen", '0, BW'(1));
   endtask

   int c0, prev, nrr, bad;
   bit seen;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; req0 = '0; req1 = '0; we = '0;
      addr  = {64'h80, 64'h40, 64'h10};
      wdata = {WD2, WD1, WD0};
      resp_delay = 1; resp_data = PAT_A5;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant",  BW'(d0_grant), '0);
      chk("rst_done",   BW'(d0_done),  '0);
      chk("rst_err",    BW'(d0_err),   '0);
      chk("rst_rdata",  d0_rdata,      '0);
      chk("rst_tmo",    BW'(d0_tmo),   '0);
      chk("rst_addr",   BW'(d0_addr),  '0);
      chk("rst_blk",    d0_blk,        '0);
      chk("rst_rstart", BW'(d0_rs),    '0);
      chk("rst_wstart", BW'(d0_ws),    '0);
      chk("rst_grant1", BW'(d1_grant), '0);
      @(posedge clk); #1 rstn = 1'b1;

      // fixed priority, 3'b110 held: ch1 then ch2, both reads of A5
      push0(3'b010, 1'b0, PAT_A5, 64'h40);
      push0(3'b100, 1'b0, PAT_A5, 64'h80);
      @(posedge clk); #1 req0 = 3'b110; c0 = cyc;
      watch0(20, 0, 64'h40, '0, 0);
      chk("fp1_grant",     BW'(ws_grant),     BW'(3'b010));
      chk("fp1_start_lat", BW'(ws_start - c0), BW'(1));
      chk("fp1_done_lat",  BW'(ws_done - c0),  BW'(3));
      chk("fp1_rd_starts", BW'(ws_nrd),        BW'(1));
      chk("fp1_wr_starts", BW'(ws_nwr),        '0);
      chk("fp1_addr_stab", BW'(ws_bad),        '0);
      prev = ws_done;
      watch0(20, 0, 64'h80, '0, 0);
      chk("fp2_grant",     BW'(ws_grant),        BW'(3'b100));
      chk("fp2_idle_gap",  BW'(ws_start - prev), BW'(2));
      chk("fp2_done_lat",  BW'(ws_done - prev),  BW'(4));
      chk("fp2_rd_starts", BW'(ws_nrd),          BW'(1));
      chk("fp2_addr_stab", BW'(ws_bad),          '0);
      @(negedge clk);
      chk("fp_done_single", BW'(d0_done), '0);

      // ch2 write, request dropped right after start
      we = 3'b100; resp_data = PAT_5A; resp_delay = 2;
      push0(3'b100, 1'b0, PAT_A5, 64'h80);
      @(posedge clk); #1 req0 = 3'b100; c0 = cyc;
      watch0(20, 1, 64'h80, WD2, 1);
      chk("wr_grant",     BW'(ws_grant),      BW'(3'b100));
      chk("wr_wr_starts", BW'(ws_nwr),        BW'(1));
      chk("wr_rd_starts", BW'(ws_nrd),        '0);
      chk("wr_done_lat",  BW'(ws_done - c0),  BW'(4));
      chk("wr_blk_stab",  BW'(ws_bad),        '0);
      chk("wr_rdata_kept", d0_rdata,          PAT_A5);

      // timeout: ch0 read, engine never answers
      we = 3'b000; resp_delay = 0;
      push0(3'b001, 1'b1, PAT_A5, 64'h10);
      @(posedge clk); #1 req0 = 3'b001;
      watch0(40, 0, 64'h10, '0, 0);
      chk("tmo_grant",    BW'(ws_grant),           BW'(3'b001));
      chk("tmo_lat",      BW'(ws_done - ws_start), BW'(1 + TMO));
      chk("tmo_flag",     BW'(d0_tmo),             BW'(1));
      @(negedge clk);
      chk("tmo_err_pulse", BW'(d0_err), '0);
      repeat (3) @(negedge clk);
      chk("tmo_sticky",    BW'(d0_tmo), BW'(1));

      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      chk("tmo_cleared_by_rst", BW'(d0_tmo), '0);
      chk("rdata_cleared",      d0_rdata,    '0);

      // done arrives on the cycle the counter reaches TIMEOUT: done wins
      resp_data = PAT_C3; resp_delay = TMO;
      push0(3'b010, 1'b0, PAT_C3, 64'h40);
      @(posedge clk); #1 req0 = 3'b010;
      watch0(40, 0, 64'h40, '0, 0);
      chk("race_lat",  BW'(ws_done - ws_start), BW'(1 + TMO));
      chk("race_tmo",  BW'(d0_tmo),             '0);
      @(negedge clk);
      chk("race_tmo_after", BW'(d0_tmo), '0);

      // reset while in WAIT, then a stray i_axi_done
      resp_delay = 2;
      @(posedge clk); #1 req0 = 3'b001;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (d0_rs === 1'b1) seen = 1;
      end
      chk("rstw_start_seen", BW'(seen), BW'(1));
      @(posedge clk); #1 rstn = 1'b0; req0 = '0;
      @(posedge clk); #1 rstn = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if ((|{d0_done, d0_grant, d0_rs, d0_ws, d0_err}) !== 1'b0) bad++;
      end
      chk("rstw_no_activity", BW'(bad),     '0);
      chk("rstw_rdata",       d0_rdata,     '0);
      chk("rstw_addr",        BW'(d0_addr), '0);
      chk("rstw_blk",         d0_blk,       '0);
      chk("rstw_tmo",         BW'(d0_tmo),  '0);

      // round-robin on dut1: 3'b111 held -> ch0, ch1, ch2, ch0
      resp_delay = 1; resp_data = PAT_A5;
      q1.push_back(3'b001); q1.push_back(3'b010);
      q1.push_back(3'b100); q1.push_back(3'b001);
      @(posedge clk); #1 req1 = 3'b111;
      nrr = 0;
      for (int i = 0; i < 60 && nrr < 4; i++) begin
         @(negedge clk);
         if ((|d1_done) === 1'b1) begin
            nrr++;
            if (nrr == 4) req1 = '0;
         end
      end
      chk("rr_done_count", BW'(nrr), BW'(4));

      repeat (5) @(negedge clk);
      chk("sb0_drained", BW'(q0.size()), '0);
      chk("sb1_drained", BW'(q1.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
